// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with a valid/ready handshake on both sides.
// Optional build macro PISO_PARITY_EN appends an even-parity beat to every word.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             sout,
   output logic             sout_valid,
   input  logic             out_ready,
   output logic             last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
   localparam int NBEATS = WIDTH + 1;
`else
   localparam int NBEATS = WIDTH;
`endif
   localparam logic [CW-1:0] FINAL_IDX = CW'(NBEATS - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             data_bit_s;
   logic             capture_s;
   logic             beat_acc_s;
`ifdef PISO_PARITY_EN
   logic             par_q, par_d;

   function automatic logic even_parity(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction
`endif

   // Output decode from the registered state
   always_comb begin
      busy       = (state_q == SHIFT);
      sout_valid = busy;
      last       = busy && (cnt_q == FINAL_IDX);
      in_ready   = !busy || (last && out_ready);
      if (MSB_FIRST != 0) begin
         data_bit_s = shreg_q[WIDTH-1];
      end else begin
         data_bit_s = shreg_q[0];
      end
      if (busy) begin
`ifdef PISO_PARITY_EN
         if (cnt_q == CW'(WIDTH)) begin
            sout = par_q;
         end else begin
            sout = data_bit_s;
         end
`else
         sout = data_bit_s;
`endif
      end else begin
         sout = 1'b0;
      end
      capture_s  = in_valid && in_ready;
      beat_acc_s = sout_valid && out_ready;
   end

   // Next-state: capture, beat advance, and return to idle
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (capture_s) begin
               state_d = SHIFT;
               shreg_d = in_data;
               cnt_d   = '0;
`ifdef PISO_PARITY_EN
               par_d   = even_parity(in_data);
`endif
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (beat_acc_s) begin
               if (last) begin
                  // a capture on the final accepted beat reloads with no bubble
                  if (capture_s) begin
                     state_d = SHIFT;
                     shreg_d = in_data;
                     cnt_d   = '0;
`ifdef PISO_PARITY_EN
                     par_d   = even_parity(in_data);
`endif
                  end else begin
                     state_d = IDLE;
                     shreg_d = '0;
                     cnt_d   = '0;
`ifdef PISO_PARITY_EN
                     par_d   = 1'b0;
`endif
                  end
               end else begin
                  if (MSB_FIRST != 0) begin
                     shreg_d = shreg_q << 1;
                  end else begin
                     shreg_d = shreg_q >> 1;
                  end
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
`ifdef PISO_PARITY_EN
            par_d   = 1'b0;
`endif
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
`ifdef PISO_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Table-driven cycle checks plus a serial-bit scoreboard for piso_serializer
// (WIDTH=4, MSB first); honours PISO_PARITY_EN when defined.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
   localparam logic PAR = 1'b1;
`else
   localparam logic PAR = 1'b0;
`endif
   localparam logic NP = ~PAR;
   localparam logic [4:0] IDLE_E = 5'b00010;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       sout;
   logic       sout_valid;
   logic       out_ready;
   logic       last;
   logic       busy;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic       rst;
      logic       iv;
      logic [3:0] id;
      logic       ordy;
      logic [4:0] exp;   // {sout_valid, sout, last, in_ready, busy}
   } vec_t;

   typedef struct {
      logic b;
      logic l;
   } beat_t;

   vec_t  tbl[$];
   beat_t exp_q[$];

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sout      (sout),
      .sout_valid(sout_valid),
      .out_ready (out_ready),
      .last      (last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] bt(input logic so, input logic l, input logic ir);
      return {1'b1, so, l, ir, 1'b1};
   endfunction

   task automatic add(input logic rst, input logic iv, input logic [3:0] id,
                      input logic ordy, input logic [4:0] e);
      vec_t v;
      v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic push_word(input logic [3:0] d);
      beat_t e;
      for (int i = 3; i >= 0; i--) begin
         e.b = d[i];
         e.l = (i == 0) && !PAR;
         exp_q.push_back(e);
      end
      if (PAR) begin
         e.b = ^d;
         e.l = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   // Called just before a rising edge: score accepted beats, track captures, advance.
   task automatic step();
      beat_t e;
      if (reset && sout_valid && out_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected got sout=%b last=%b want no beat", sout, last);
         end else begin
            e = exp_q.pop_front();
            if ({sout, last} !== {e.b, e.l}) begin
               n_bad++;
               $display("FAIL sb_beat got sout/last=%b%b want %b%b", sout, last, e.b, e.l);
            end
         end
      end
      if (!reset) begin
         exp_q.delete();
      end else if (in_valid && in_ready) begin
         push_word(in_data);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic got;

      // idle after reset
      add(1'b1, 1'b0, 4'h0, 1'b1, IDLE_E);
      // 1011 at full rate
      add(1'b1, 1'b1, 4'b1011, 1'b1, IDLE_E);
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, NP, NP));
`ifdef PISO_PARITY_EN
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b1, 1'b1));
`endif
      add(1'b1, 1'b0, 4'h0, 1'b1, IDLE_E);
      // stall three cycles on the second bit
      add(1'b1, 1'b1, 4'b1011, 1'b1, IDLE_E);
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b0, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b0, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b0, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, NP, NP));
`ifdef PISO_PARITY_EN
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b1, 1'b1));
`endif
      add(1'b1, 1'b0, 4'h0, 1'b1, IDLE_E);
      // back-to-back words with in_valid held
      add(1'b1, 1'b1, 4'b1011, 1'b1, IDLE_E);
      add(1'b1, 1'b1, 4'b0100, 1'b1, bt(1'b1, 1'b0, 1'b0));
      add(1'b1, 1'b1, 4'b0100, 1'b1, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b1, 4'b0100, 1'b1, bt(1'b1, 1'b0, 1'b0));
      add(1'b1, 1'b1, 4'b0100, 1'b1, bt(1'b1, NP, NP));
`ifdef PISO_PARITY_EN
      add(1'b1, 1'b1, 4'b0100, 1'b1, bt(1'b1, 1'b1, 1'b1));
`endif
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b0, NP, NP));
`ifdef PISO_PARITY_EN
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b1, 1'b1));
`endif
      add(1'b1, 1'b0, 4'h0, 1'b1, IDLE_E);
      // 1111 offered mid-word is ignored
      add(1'b1, 1'b1, 4'b1011, 1'b1, IDLE_E);
      add(1'b1, 1'b1, 4'b1111, 1'b1, bt(1'b1, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, NP, NP));
`ifdef PISO_PARITY_EN
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b1, 1'b1));
`endif
      add(1'b1, 1'b0, 4'h0, 1'b1, IDLE_E);
      // reset mid-word, then 0001
      add(1'b1, 1'b1, 4'b1011, 1'b1, IDLE_E);
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b0, 1'b0));
      add(1'b0, 1'b0, 4'h0, 1'b1, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b1, 4'b0001, 1'b1, IDLE_E);
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b0, 1'b0, 1'b0));
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, NP, NP));
`ifdef PISO_PARITY_EN
      add(1'b1, 1'b0, 4'h0, 1'b1, bt(1'b1, 1'b1, 1'b1));
`endif
      add(1'b1, 1'b0, 4'h0, 1'b1, IDLE_E);
      // reset wins over a capture
      add(1'b0, 1'b1, 4'b1111, 1'b1, IDLE_E);
      add(1'b1, 1'b0, 4'h0, 1'b1, IDLE_E);

      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         reset     = tbl[i].rst;
         in_valid  = tbl[i].iv;
         in_data   = tbl[i].id;
         out_ready = tbl[i].ordy;
         #1;
         n_vec++;
         if ({sout_valid, sout, last, in_ready, busy} !== tbl[i].exp) begin
            n_bad++;
            $display("FAIL vec%0d got sv/so/last/rdy/busy=%b want %b", i,
                     {sout_valid, sout, last, in_ready, busy}, tbl[i].exp);
         end
         step();
      end

      // random words under random downstream stalls
      reset = 1'b1;
      for (int w = 0; w < 8; w++) begin
         in_valid = 1'b1;
         in_data  = 4'($urandom_range(0, 15));
         got      = 1'b0;
         for (int c = 0; c < 40 && !got; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            got = in_ready;
            step();
         end
         in_valid = 1'b0;
         n_vec++;
         if (!got) begin
            n_bad++;
            $display("FAIL capture_timeout got in_ready=0 want 1 within 40 cycles");
         end
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && busy; c++) begin
         #1;
         step();
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_busy got %b want 0", busy);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_leftover got %0d pending beats want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH SHALL be declared: default 4; bits per parallel word.
REQ-002 Parameter MSB_FIRST SHALL be declared: default 1; 1 = shift MSB first, 0 = LSB first.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 Port in_data  input  WIDTH  SHALL be the parallel word from the upstream parallel register q output.
REQ-006 Port in_valid  input  1  SHALL indicate in_data is offered for capture.
REQ-007 Port in_ready  output  1  SHALL indicate the block accepts a word this cycle.
REQ-008 Port sout  output  1  SHALL be the current serial bit.
REQ-009 Port sout_valid  output  1  SHALL qualify sout.
REQ-010 Port out_ready  input  1  SHALL be the downstream acceptance of the current bit.
REQ-011 Port last  output  1  SHALL flag the final beat of a word.
REQ-012 Port busy  output  1  SHALL be high while a word is being serialized.

Function
REQ-013 States SHALL be exactly IDLE and SHIFT.
REQ-014 Capture SHALL occur at a rising edge where in_valid && in_ready; data goes to the shift register, beat counter = 0, state = SHIFT.
REQ-015 in_ready SHALL be 1 in IDLE, and in SHIFT only when last && out_ready (final beat accepted this cycle); otherwise 0.
REQ-016 Capture coinciding with final-beat acceptance SHALL load the new word with no bubble cycle.
REQ-017 First bit SHALL appear on sout with sout_valid=1 in the cycle after capture (1-cycle latency).
REQ-018 In SHIFT, sout_valid SHALL be 1; sout = shreg[WIDTH-1] if MSB_FIRST else shreg[0].
REQ-019 A beat SHALL advance (shift by one, counter +1) only on an edge with sout_valid && out_ready; with out_ready=0, sout, last and counter SHALL hold.
REQ-020 last SHALL be 1 exactly when counter == final beat index (WIDTH-1 without parity).
REQ-021 Final beat accepted with no capture SHALL return to IDLE.
REQ-022 In IDLE: sout=0, sout_valid=0, last=0, busy=0; in_valid SHALL be ignored only when in_ready=0.
REQ-023 busy SHALL equal (state == SHIFT).
REQ-024 Counter width SHALL be $clog2(WIDTH+1) bits; counter SHALL never exceed the final beat index.

Reset
REQ-025 reset low at a rising edge SHALL force IDLE, shift register 0, counter 0, taking priority over capture and shift.
REQ-026 After reset edge: sout=0, sout_valid=0, last=0, busy=0, in_ready=1.
REQ-027 reset mid-word SHALL abort the word; no remaining bits are emitted.

Configuration
REQ-028 Macro PISO_PARITY_EN defined: each word SHALL carry WIDTH+1 beats; extra final beat = even parity (XOR of captured in_data); last on the parity beat.
REQ-029 Macro PISO_PARITY_EN undefined: each word SHALL carry exactly WIDTH beats; no parity logic present.

Verification (WIDTH=4, MSB_FIRST=1)
REQ-030 Reset held low 2 cycles then released -> sout_valid=0, busy=0, in_ready=1, sout=0.
REQ-031 in_data=4'b1011 pulsed with in_valid, out_ready=1 -> sout 1,0,1,1 on 4 consecutive cycles from capture+1, last on 4th; with PISO_PARITY_EN a 5th beat sout=1 with last.
REQ-032 out_ray=0 for 3 cycles while 2nd bit (0) of 4'b1011 is shown -> sout=0, last=0 held 3 cycles, then sequence resumes 1,1.
REQ-033 4'b1011 then 4'b0100 with in_valid held high -> in_ready=1 only on the final beat; sout 1,0,1,1,0,1,0,0 contiguous, no gap.
REQ-034 in_valid=1 with in_data=4'b1111 during a non-final beat -> in_ready=0, word not captured, current sequence unaffected.
REQ-035 reset low during 2nd beat of 4'b1011, then released and 4'b0001 sent -> sout_valid=0 next cycle, then 0,0,0,1 with last on 4th.
